// File: rtl/sevenseg_pkg.sv
// Shared types, segment table and constants for the seven-segment scanner.
package sevenseg_pkg;

    localparam int unsigned PHASES = 16;

    typedef logic [6:0] seg7_t;

    // Segment order {a,b,c,d,e,f,g}, logical 1 = lit.
    localparam seg7_t HEX2SEG [PHASES] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic seg7_t hex2seg(input logic [3:0] value);
        return HEX2SEG[value];
    endfunction

endpackage

// File: rtl/sevenseg_lzs.sv
// Leading-zero mask: digit i (i > 0) is suppressed when nibbles i..top are all zero.
module sevenseg_lzs
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] nibbles,
    input  logic                    lzs_en,
    output logic [NUM_DIGITS-1:0]   lz_supp
);

    logic zero_above;

    always_comb begin
        lz_supp    = '0;
        zero_above = 1'b1;
        // Walk down from the most significant digit; digit 0 is never touched.
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (nibbles[4*i +: 4] == 4'd0);
            lz_supp[i] = lzs_en & zero_above;
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment driver with frame snapshot, LZS, blanking and PWM.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned DIV            = 4096,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] datain,
    input  logic [NUM_DIGITS-1:0]   dpin,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lzs_en,
    input  logic [3:0]              bright,
    output logic [6:0]              display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   grounds,
    output logic                    frame_start
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [3:0]              phase;
    logic [IDX_W-1:0]        idx;
    logic                    first_frame;

    logic [4*NUM_DIGITS-1:0] data_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic [NUM_DIGITS-1:0]   blank_snap;
    logic                    lzs_snap;
    logic [3:0]              bright_snap;

    logic [6:0]              display_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   grounds_q;
    logic                    frame_start_q;

    logic                    tick;
    logic                    last_slot;
    logic                    idx_wrap;
    logic                    snap;
    logic [NUM_DIGITS-1:0]   lz_supp;
    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [3:0]              cur_nib;
    logic                    lit;
    logic [6:0]              display_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   grounds_d;

    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign last_slot = tick && (phase == 4'(PHASES - 1));
    assign idx_wrap  = last_slot && (idx == IDX_W'(NUM_DIGITS - 1));
    // The first cycle out of reset counts as a wrap so a frame is captured at once.
    assign snap      = first_frame | idx_wrap;

    sevenseg_lzs #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzs (
        .nibbles (data_snap),
        .lzs_en  (lzs_snap),
        .lz_supp (lz_supp)
    );

    always_comb begin
        blank_eff = blank_snap | lz_supp;
        cur_nib   = data_snap[{idx, 2'b00} +: 4];
        lit       = (phase < bright_snap) && !blank_eff[idx];
        display_d = 7'd0;
        dp_d      = 1'b0;
        grounds_d = '0;
        if (lit) begin
            display_d = hex2seg(cur_nib);
            dp_d      = dp_snap[idx];
            grounds_d = NUM_DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt       <= '0;
            phase         <= '0;
            idx           <= '0;
            first_frame   <= 1'b1;
            data_snap     <= '0;
            dp_snap       <= '0;
            blank_snap    <= '0;
            lzs_snap      <= 1'b0;
            bright_snap   <= '0;
            display_q     <= '0;
            dp_q          <= 1'b0;
            grounds_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            first_frame <= 1'b0;
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                phase <= phase + 4'd1;
            end
            if (last_slot) begin
                idx <= idx_wrap ? '0 : idx + 1'b1;
            end
            if (snap) begin
                data_snap   <= datain;
                dp_snap     <= dpin;
                blank_snap  <= blank;
                lzs_snap    <= lzs_en;
                bright_snap <= bright;
            end
            display_q     <= display_d;
            dp_q          <= dp_d;
            grounds_q     <= grounds_d;
            frame_start_q <= snap;
        end
    end

    assign display     = display_q ^ {7{SEG_ACTIVE_LOW}};
    assign dp          = dp_q ^ SEG_ACTIVE_LOW;
    assign grounds     = grounds_q ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: table of frame records, per-cycle scoreboard on two polarities.
module tb_sevenseg_scan;

    localparam int F = 128;  // 16 phases * DIV 2 * 4 digits

    typedef struct packed {
        logic [15:0] datain;
        logic [3:0]  dpin;
        logic [3:0]  blank;
        logic        lzs;
        logic [3:0]  bright;
        logic [3:0]  exp_on;
        logic [3:0]  exp_dp;
        logic [27:0] exp_seg;  // digit i at [7i +: 7]
    } vec_t;

    typedef struct packed {
        logic       fs;
        logic [3:0] grounds;
        logic [6:0] display;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] datain;
    logic [3:0]  dpin;
    logic [3:0]  blank;
    logic        lzs_en;
    logic [3:0]  bright;

    logic [6:0]  display0, display1;
    logic        dp0, dp1, fs0, fs1;
    logic [3:0]  grounds0, grounds1;

    vec_t vec [8];
    exp_t q [$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .NUM_DIGITS     (4),
        .DIV            (2),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .datain      (datain),
        .dpin        (dpin),
        .blank       (blank),
        .lzs_en      (lzs_en),
        .bright      (bright),
        .display     (display0),
        .dp          (dp0),
        .grounds     (grounds0),
        .frame_start (fs0)
    );

    sevenseg_scan #(
        .NUM_DIGITS     (4),
        .DIV            (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) u_inv (
        .clk         (clk),
        .reset       (reset),
        .datain      (datain),
        .dpin        (dpin),
        .blank       (blank),
        .lzs_en      (lzs_en),
        .bright      (bright),
        .display     (display1),
        .dp          (dp1),
        .grounds     (grounds1),
        .frame_start (fs1)
    );

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        total++;
        if (act !== req) begin
            $display("FAIL %s @%0t: got fs/gnd/seg/dp=%b_%b_%b_%b want %b_%b_%b_%b", name, $time,
                     act[12], act[11:8], act[7:1], act[0], req[12], req[11:8], req[7:1], req[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic apply(input int r);
        datain = vec[r].datain;
        dpin   = vec[r].dpin;
        blank  = vec[r].blank;
        lzs_en = vec[r].lzs;
        bright = vec[r].bright;
    endtask

    // Expected logical outputs after the edge that ends scan position k, given snapshot s.
    function automatic exp_t expect_at(input int k, input int s);
        exp_t e;
        int   ph;
        int   dig;
        ph        = (k / 2) % 16;
        dig       = (k / 32) % 4;
        e         = '0;
        e.fs      = (k == 0) || (k % F == F - 1);
        if (s >= 0 && vec[s].exp_on[dig] && ph < int'(vec[s].bright)) begin
            e.grounds = 4'b0001 << dig;
            e.display = vec[s].exp_seg[7*dig +: 7];
            e.dp      = vec[s].exp_dp[dig];
        end
        return e;
    endfunction

    task automatic compare_both(input string tag, input exp_t e);
        check(tag, {fs0, grounds0, display0, dp0}, e);
        check({tag, "_inv"}, {fs1, grounds1, display1, dp1}, {e.fs, ~e.grounds, ~e.display, ~e.dp});
    endtask

    // Run n cycles from a fresh reset release; record 'first' is captured first, then the
    // next record is driven mid-frame so it only appears after the following snapshot.
    task automatic run(input int first, input int last, input int n, input string tag);
        int   cur;
        int   snap;
        exp_t e;
        cur  = first;
        snap = -1;
        apply(cur);
        for (int k = 0; k < n; k++) begin
            q.push_back(expect_at(k, snap));
            if (k == 0 || k % F == F - 1) begin
                snap = cur;
                if (cur < last) cur++;
            end
            @(posedge clk);
            @(negedge clk);
            e = q.pop_front();
            compare_both(tag, e);
            apply(cur);
        end
    endtask

    task automatic reset_cycles(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_both("reset", '0);
        end
        reset = 1'b0;
    endtask

    initial begin
        vec[0] = '{16'h1A3F, 4'b0000, 4'b0000, 1'b0, 4'd15, 4'b1111, 4'b0000,
                   {7'b0110000, 7'b1110111, 7'b1111001, 7'b1000111}};
        vec[1] = '{16'h1A3F, 4'b0101, 4'b0000, 1'b0, 4'd4, 4'b1111, 4'b0101,
                   {7'b0110000, 7'b1110111, 7'b1111001, 7'b1000111}};
        vec[2] = '{16'h1A3F, 4'b1111, 4'b0000, 1'b0, 4'd0, 4'b1111, 4'b1111,
                   {7'b0110000, 7'b1110111, 7'b1111001, 7'b1000111}};
        vec[3] = '{16'h0050, 4'b1100, 4'b0000, 1'b1, 4'd15, 4'b0011, 4'b0000,
                   {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
        vec[4] = '{16'h0000, 4'b0011, 4'b0000, 1'b1, 4'd15, 4'b0001, 4'b0001,
                   {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        vec[5] = '{16'h8E20, 4'b1111, 4'b0010, 1'b1, 4'd9, 4'b1101, 4'b1101,
                   {7'b1111111, 7'b1001111, 7'b0000000, 7'b1111110}};
        vec[6] = '{16'h0A00, 4'b0000, 4'b0000, 1'b1, 4'd15, 4'b0111, 4'b0000,
                   {7'b0000000, 7'b1110111, 7'b1111110, 7'b1111110}};
        vec[7] = '{16'h4567, 4'b1000, 4'b0000, 1'b0, 4'd1, 4'b1111, 4'b1000,
                   {7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000}};

        // Junk on the inputs during reset must never be displayed.
        datain = 16'hFFFF;
        dpin   = 4'hF;
        blank  = 4'h0;
        lzs_en = 1'b0;
        bright = 4'd15;

        reset_cycles(5);
        run(0, 7, 8 * F, "frames");
        reset_cycles(2);
        run(0, 0, F + 40, "pre_rst");
        reset_cycles(1);
        run(3, 5, 3 * F, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
